pitch_shade_filter: RTL and testbench

Parametrised successor to the pitch-to-gray mapper in the drone display path. It quantises a tilt/height sample `z` into one of LEVELS buckets, using hysteresis and a consecutive-sample debounce. It then fades a grayscale shade toward that level's gray, stepping once per video frame tick. Output `color` feeds the overlay renderer as packed {R,G,B}.

---
 rtl/pitch_shade_pkg.sv | 32 +++
 rtl/pitch_shade_filter_if.sv | 15 +
 rtl/pitch_level_quantizer.sv | 37 +++
 rtl/pitch_shade_filter.sv | 114 +++++++++++
 tb/tb_pitch_shade_filter.sv | 129 ++++++++++++
 5 files changed

// File: rtl/pitch_shade_pkg.sv
// Shared types, default constants and gray-mapping helpers for the pitch shade filter.
package pitch_shade_pkg;

    localparam int unsigned DEF_MAX_Z     = 300;
    localparam int unsigned DEF_LEVELS    = 8;
    localparam int unsigned DEF_GRAY_MIN  = 75;
    localparam int unsigned DEF_GRAY_STEP = 25;

    typedef enum logic {
        STABLE  = 1'b0,
        QUALIFY = 1'b1
    } state_t;

    function automatic int unsigned level_width(input int unsigned levels);
        return (levels <= 2) ? 1 : $clog2(levels);
    endfunction

    // Level 0 is always white; higher levels darken linearly down to gmin at the top level.
    function automatic logic [7:0] target_gray(input int unsigned lvl,
                                               input int unsigned levels,
                                               input int unsigned gmin,
                                               input int unsigned gstep);
        if (lvl == 0)
            return 8'd255;
        return 8'(gmin + (levels - 1 - lvl) * gstep);
    endfunction

    function automatic logic [23:0] pack_gray(input logic [7:0] shade);
        return {shade, shade, shade};
    endfunction

endpackage

// File: rtl/pitch_shade_filter_if.sv
// Sample/frame inputs and level/colour outputs of the pitch shade filter.
interface pitch_shade_filter_if #(
    parameter int Z_WIDTH = 16,
    parameter int LW      = 3
);
    logic [Z_WIDTH-1:0] z;
    logic               z_valid;
    logic               frame_tick;
    logic [LW-1:0]      level;
    logic [23:0]        color;
    logic               busy;

    modport master (output z, z_valid, frame_tick, input level, color, busy);
    modport slave  (input z, z_valid, frame_tick, output level, color, busy);
endinterface

// File: rtl/pitch_level_quantizer.sv
// Combinational bucket quantiser: raw level from z, then hysteresis against the accepted level.
module pitch_level_quantizer #(
    parameter int Z_WIDTH = 16,
    parameter int MAX_Z   = 300,
    parameter int LEVELS  = 8,
    parameter int HYST    = 4,
    parameter int LW      = 3
) (
    input  logic [Z_WIDTH-1:0] z,
    input  logic [LW-1:0]      a,
    output logic [LW-1:0]      r,
    output logic [LW-1:0]      c
);
    localparam int unsigned B = MAX_Z / LEVELS;
    localparam int W = Z_WIDTH + 1;

    logic [W-1:0] zx;
    logic [W-1:0] up_thr;
    logic [W-1:0] dn_base;

    always_comb begin
        zx = {1'b0, z};
        r  = '0;
        // Thresholds rise monotonically, so the last one exceeded equals the count.
        for (int unsigned k = 1; k < LEVELS; k++) begin
            if (zx > W'(k * B))
                r = LW'(k);
        end
        up_thr  = W'(r) * W'(B) + W'(HYST);
        dn_base = (W'(r) + W'(1)) * W'(B);
        c = a;
        if (r > a && zx > up_thr)
            c = r;
        else if (r < a && dn_base >= W'(HYST) && zx <= dn_base - W'(HYST))
            c = r;
    end
endmodule

// File: rtl/pitch_shade_filter.sv
// Debounced level tracking with per-frame gray fade toward the level's target shade.
module pitch_shade_filter
    import pitch_shade_pkg::*;
#(
    parameter int Z_WIDTH   = 16,
    parameter int MAX_Z     = DEF_MAX_Z,
    parameter int LEVELS    = DEF_LEVELS,
    parameter int GRAY_MIN  = DEF_GRAY_MIN,
    parameter int GRAY_STEP = DEF_GRAY_STEP,
    parameter int HYST      = 4,
    parameter int SETTLE    = 3,
    parameter int FADE_STEP = 10
) (
    input logic clk,
    input logic reset,
    pitch_shade_filter_if.slave bus
);
    localparam int LW = level_width(LEVELS);
    localparam int CW = $clog2(SETTLE + 1);

    state_t        state_q, state_d;
    logic [LW-1:0] level_q, level_d, pend_q, pend_d, cand, raw, commit_lvl;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          commit;
    logic [7:0]    shade_q, shade_d, tgt_now;
    logic [23:0]   color_q;
    logic          busy_q, busy_d;

    pitch_level_quantizer #(
        .Z_WIDTH(Z_WIDTH), .MAX_Z(MAX_Z), .LEVELS(LEVELS), .HYST(HYST), .LW(LW)
    ) u_quant (
        .z(bus.z), .a(level_q), .r(raw), .c(cand)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= STABLE;
            pend_q  <= '0;
            cnt_q   <= '0;
            level_q <= '0;
            shade_q <= 8'd255;
            color_q <= '1;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pend_q  <= pend_d;
            cnt_q   <= cnt_d;
            level_q <= level_d;
            shade_q <= shade_d;
            color_q <= pack_gray(shade_d);
            busy_q  <= busy_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pend_d  = pend_q;
        cnt_d   = cnt_q;
        commit  = 1'b0;
        if (bus.z_valid) begin
            case (state_q)
                STABLE: if (cand != level_q) begin
                    if (SETTLE == 1) begin
                        commit = 1'b1;
                    end else begin
                        pend_d  = cand;
                        cnt_d   = CW'(1);
                        state_d = QUALIFY;
                    end
                end
                QUALIFY: begin
                    if (cand == pend_q) begin
                        if (32'(cnt_q) + 1 >= SETTLE) begin
                            commit  = 1'b1;
                            cnt_d   = '0;
                            state_d = STABLE;
                        end else begin
                            cnt_d = cnt_q + CW'(1);
                        end
                    end else if (cand == level_q) begin
                        cnt_d   = '0;
                        state_d = STABLE;
                    end else begin
                        pend_d = cand;
                        cnt_d  = CW'(1);
                    end
                end
                default: state_d = STABLE;
            endcase
        end
    end

    always_comb begin
        commit_lvl = (state_q == STABLE) ? cand : pend_q;
        level_d    = commit ? commit_lvl : level_q;
    end

    // Fade steps toward the pre-commit target; busy compares against the post-commit one.
    always_comb begin
        tgt_now = target_gray(32'(level_q), LEVELS, GRAY_MIN, GRAY_STEP);
        shade_d = shade_q;
        if (bus.frame_tick) begin
            if (shade_q < tgt_now)
                shade_d = (tgt_now - shade_q > 8'(FADE_STEP)) ? shade_q + 8'(FADE_STEP) : tgt_now;
            else if (shade_q > tgt_now)
                shade_d = (shade_q - tgt_now > 8'(FADE_STEP)) ? shade_q - 8'(FADE_STEP) : tgt_now;
        end
        busy_d = (shade_d != target_gray(32'(level_d), LEVELS, GRAY_MIN, GRAY_STEP));
    end

    assign bus.level = level_q;
    assign bus.color = color_q;
    assign bus.busy  = busy_q;
endmodule

// File: tb/tb_pitch_shade_filter.sv
// Directed-vector bench for pitch_shade_filter at default parameters.
module tb_pitch_shade_filter;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int tests_run = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    pitch_shade_filter_if #(.Z_WIDTH(16), .LW(3)) bus ();

    pitch_shade_filter #(
        .Z_WIDTH(16), .MAX_Z(300), .LEVELS(8), .GRAY_MIN(75), .GRAY_STEP(25),
        .HYST(4), .SETTLE(3), .FADE_STEP(10)
    ) dut (
        .clk(clk), .reset(reset), .bus(bus)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cyc(input logic v, input logic [15:0] zz, input logic t);
        @(negedge clk);
        bus.z          = zz;
        bus.z_valid    = v;
        bus.frame_tick = t;
        @(posedge clk);
        #1;
        bus.z_valid    = 1'b0;
        bus.frame_tick = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    function automatic logic [31:0] gray(input int s);
        return {8'h00, s[7:0], s[7:0], s[7:0]};
    endfunction

    initial begin
        bus.z = '0;
        bus.z_valid = 1'b0;
        bus.frame_tick = 1'b0;
        do_reset();
        check("rst_level", 32'(bus.level), 0);
        check("rst_color", 32'(bus.color), 32'hFFFFFF);
        check("rst_busy", 32'(bus.busy), 0);

        // 1: full-scale climb to level 7 then fade to 75
        cyc(1, 300, 0); check("t1_lvl_a", 32'(bus.level), 0);
        cyc(1, 300, 0); check("t1_lvl_b", 32'(bus.level), 0);
        cyc(1, 300, 0); check("t1_lvl_c", 32'(bus.level), 7);
        check("t1_busy0", 32'(bus.busy), 1);
        for (int i = 1; i <= 18; i++) begin
            cyc(0, 0, 1);
            check("t1_shade", 32'(bus.color), gray(255 - 10 * i));
            check("t1_busy", 32'(bus.busy), (i < 18) ? 1 : 0);
        end
        check("t1_final", 32'(bus.color), 32'h4B4B4B);

        // 2: hysteresis up
        do_reset();
        for (int i = 0; i < 5; i++) begin
            cyc(1, 39, 0); check("t2_hold", 32'(bus.level), 0);
        end
        cyc(1, 42, 0); cyc(1, 42, 0); check("t2_pre", 32'(bus.level), 0);
        cyc(1, 42, 0); check("t2_lvl", 32'(bus.level), 1);
        for (int i = 1; i <= 3; i++) begin
            cyc(0, 0, 1); check("t2_shade", 32'(bus.color), gray(255 - 10 * i));
        end
        check("t2_busy", 32'(bus.busy), 0);

        // 3: hysteresis down
        for (int i = 0; i < 5; i++) begin
            cyc(1, 36, 0); check("t3_hold", 32'(bus.level), 1);
        end
        cyc(1, 33, 0); cyc(1, 33, 0); check("t3_pre", 32'(bus.level), 1);
        cyc(1, 33, 0); check("t3_lvl", 32'(bus.level), 0);
        check("t3_busy1", 32'(bus.busy), 1);
        for (int i = 1; i <= 3; i++) begin
            cyc(0, 0, 1); check("t3_shade", 32'(bus.color), gray(225 + 10 * i));
        end
        check("t3_busy", 32'(bus.busy), 0);

        // 4: debounce break
        cyc(1, 300, 0); cyc(1, 300, 0); cyc(1, 10, 0);
        check("t4_abort", 32'(bus.level), 0);
        cyc(1, 300, 0); cyc(1, 300, 0); check("t4_hold", 32'(bus.level), 0);
        cyc(1, 300, 0); check("t4_lvl", 32'(bus.level), 7);

        // 5: reset mid-fade and mid-qualify
        for (int i = 0; i < 9; i++) cyc(0, 0, 1);
        check("t5_mid", 32'(bus.color), 32'hA5A5A5);
        check("t5_busy", 32'(bus.busy), 1);
        cyc(1, 10, 0); cyc(1, 10, 0);
        check("t5_qual", 32'(bus.level), 7);
        do_reset();
        check("t5_color", 32'(bus.color), 32'hFFFFFF);
        check("t5_level", 32'(bus.level), 0);
        check("t5_busy0", 32'(bus.busy), 0);
        cyc(1, 300, 0); cyc(1, 300, 0); check("t5_cnt", 32'(bus.level), 0);
        cyc(1, 300, 0); check("t5_relvl", 32'(bus.level), 7);

        // 6: commit and frame tick on the same edge
        do_reset();
        cyc(1, 300, 0); cyc(1, 300, 0);
        cyc(1, 300, 1);
        check("t6_lvl", 32'(bus.level), 7);
        check("t6_shade", 32'(bus.color), 32'hFFFFFF);
        check("t6_busy", 32'(bus.busy), 1);
        cyc(0, 0, 1);
        check("t6_next", 32'(bus.color), 32'hF5F5F5);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
